// File: rtl/ram4002_pkg.sv
// Shared types and constants for the 4002-style RAM bank: instruction-cycle
// phases, I/O opcode (OPA) values and debug-address field positions.
package ram4002_pkg;

  // One instruction cycle is eight clocks, A1..X3; IDLE waits for the first sync.
  typedef enum logic [3:0] {
    IDLE,
    A1,
    A2,
    A3,
    M1,
    M2,
    X1,
    X2,
    X3
  } phase_t;

  // Storage is always declared at the architectural maximum; smaller
  // parameter values simply leave the upper entries unimplemented.
  localparam int MAX_REGS   = 4;
  localparam int MAX_CHARS  = 16;
  localparam int MAX_STATUS = 4;

  // E-group OPA values seen at M2 of an I/O instruction.
  localparam logic [3:0] OPA_WRM = 4'h0;
  localparam logic [3:0] OPA_WMP = 4'h1;
  localparam logic [3:0] OPA_WR0 = 4'h4;
  localparam logic [3:0] OPA_WR1 = 4'h5;
  localparam logic [3:0] OPA_WR2 = 4'h6;
  localparam logic [3:0] OPA_WR3 = 4'h7;
  localparam logic [3:0] OPA_SBM = 4'h8;
  localparam logic [3:0] OPA_RDM = 4'h9;
  localparam logic [3:0] OPA_ADM = 4'hB;
  localparam logic [3:0] OPA_RD0 = 4'hC;
  localparam logic [3:0] OPA_RD1 = 4'hD;
  localparam logic [3:0] OPA_RD2 = 4'hE;
  localparam logic [3:0] OPA_RD3 = 4'hF;

  // Debug address layout: {status_flag, reg[1:0], char[3:0]}; a status
  // access uses only the low two character bits as the status index.
  localparam int DBG_STATUS_BIT = 6;
  localparam int DBG_REG_MSB    = 5;
  localparam int DBG_REG_LSB    = 4;
  localparam int DBG_CHAR_MSB   = 3;
  localparam int DBG_CHAR_LSB   = 0;
  localparam int DBG_STAT_MSB   = 1;
  localparam int DBG_STAT_LSB   = 0;

  // WR0..WR3 occupy 0x4..0x7; the status index is opa[1:0].
  function automatic logic is_status_write(input logic [3:0] opa);
    return opa[3:2] == 2'b01;
  endfunction

  // RD0..RD3 occupy 0xC..0xF; the status index is opa[1:0].
  function automatic logic is_status_read(input logic [3:0] opa);
    return opa[3:2] == 2'b11;
  endfunction

  // SBM and ADM put the addressed main character on the bus exactly like RDM;
  // the arithmetic happens inside the CPU.
  function automatic logic is_main_read(input logic [3:0] opa);
    return (opa == OPA_SBM) || (opa == OPA_RDM) || (opa == OPA_ADM);
  endfunction

endpackage

// File: rtl/ram4002_chip.sv
// One 4002-style RAM chip: main and status character storage, the 4-bit
// output port register, the bus read mux and a combinational debug read mux.
module ram4002_chip
  import ram4002_pkg::*;
#(
  parameter int CHIP_ID    = 0,
  parameter int NUM_REGS   = 4,
  parameter int NUM_CHARS  = 16,
  parameter int NUM_STATUS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_x2,
  input  logic [1:0] chip_sel,
  input  logic [1:0] reg_sel,
  input  logic [3:0] char_sel,
  input  logic [3:0] opa,
  input  logic [3:0] data_in,
  input  logic [1:0] dbg_chip,
  input  logic [6:0] dbg_addr,
  output logic       rd_en,
  output logic [3:0] rd_data,
  output logic [3:0] port_out,
  output logic [3:0] dbg_data
);

  localparam logic [1:0] MY_ID = 2'(CHIP_ID);

  logic [3:0] main_mem   [MAX_REGS][MAX_CHARS];
  logic [3:0] status_mem [MAX_REGS][MAX_STATUS];
  logic [3:0] port_q;

  logic selected;
  logic main_ok;
  logic status_ok;
  logic wr_main;
  logic wr_status;
  logic wr_port;

  logic [1:0] dbg_reg;
  logic [3:0] dbg_char;
  logic [1:0] dbg_stat;
  logic       dbg_hit;

  // The chip only responds when the latched SRC address names an implemented register.
  assign selected  = (chip_sel == MY_ID) && (int'(reg_sel) < NUM_REGS);
  assign main_ok   = selected && (int'(char_sel) < NUM_CHARS);
  assign status_ok = selected && (int'(opa[1:0]) < NUM_STATUS);

  assign wr_main   = io_x2 && (opa == OPA_WRM) && main_ok;
  assign wr_port   = io_x2 && (opa == OPA_WMP) && selected;
  assign wr_status = io_x2 && is_status_write(opa) && status_ok;

  assign port_out = port_q;

  // Storage and port register: cleared by reset, written at the X2 edge of an I/O cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: this memory is reset explicitly because the bank must power up
      // all-zero; that forces flops rather than a RAM macro, acceptable at 80 nibbles per chip.
      for (int r = 0; r < MAX_REGS; r++) begin
        for (int c = 0; c < MAX_CHARS; c++) begin
          main_mem[r][c] <= '0;
        end
        for (int s = 0; s < MAX_STATUS; s++) begin
          status_mem[r][s] <= '0;
        end
      end
      port_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the
      // pre-edge values, so evaluation order between blocks cannot matter.
      if (wr_main) begin
        main_mem[reg_sel][char_sel] <= data_in;
      end
      if (wr_status) begin
        status_mem[reg_sel][opa[1:0]] <= data_in;
      end
      if (wr_port) begin
        port_q <= data_in;
      end
    end
  end

  // Bus read mux: drives only during X2 of a read-type I/O cycle to an implemented location.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rd_en   = 1'b0;
    rd_data = '0;
    if (io_x2) begin
      if (is_main_read(opa) && main_ok) begin
        rd_en   = 1'b1;
        rd_data = main_mem[reg_sel][char_sel];
      end else if (is_status_read(opa) && status_ok) begin
        rd_en   = 1'b1;
        rd_data = status_mem[reg_sel][opa[1:0]];
      end
    end
  end

  assign dbg_reg  = dbg_addr[DBG_REG_MSB:DBG_REG_LSB];
  assign dbg_char = dbg_addr[DBG_CHAR_MSB:DBG_CHAR_LSB];
  assign dbg_stat = dbg_addr[DBG_STAT_MSB:DBG_STAT_LSB];
  assign dbg_hit  = (dbg_chip == MY_ID) && (int'(dbg_reg) < NUM_REGS);

  // Debug read mux: unimplemented locations and other chips read as zero.
  always_comb begin
    dbg_data = '0;
    if (dbg_hit) begin
      if (dbg_addr[DBG_STATUS_BIT]) begin
        if (int'(dbg_stat) < NUM_STATUS) begin
          dbg_data = status_mem[dbg_reg][dbg_stat];
        end
      end else if (int'(dbg_char) < NUM_CHARS) begin
        dbg_data = main_mem[dbg_reg][dbg_char];
      end
    end
  end

endmodule

// File: rtl/ram_bank_4002.sv
// Bank of NUM_CHIPS 4002-style RAM chips on the multiplexed 4-bit CPU bus.
// Tracks the instruction-cycle phase, decodes SRC and E-group I/O, and merges
// the per-chip read data onto a single bus and debug port.
module ram_bank_4002
  import ram4002_pkg::*;
#(
  parameter int NUM_CHIPS  = 2,
  parameter int NUM_REGS   = 4,
  parameter int NUM_CHARS  = 16,
  parameter int NUM_STATUS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sync,
  input  logic                   cm_ram,
  input  logic [3:0]             data_in,
  output logic [3:0]             data_out,
  output logic                   data_oe,
  output logic [4*NUM_CHIPS-1:0] port_out,
  input  logic [1:0]             dbg_chip,
  input  logic [6:0]             dbg_addr,
  output logic [3:0]             dbg_data
);

  phase_t phase;
  phase_t phase_nxt;

  logic [1:0] chip_sel;
  logic [1:0] reg_sel;
  logic [3:0] char_sel;
  logic [3:0] opa;
  logic       io_cycle;
  logic       src_pending;
  logic       io_x2;

  logic       chip_rd_en   [NUM_CHIPS];
  logic [3:0] chip_rd_data [NUM_CHIPS];
  logic [3:0] chip_dbg     [NUM_CHIPS];
  logic       rd_any;
  logic [3:0] rd_or;
  logic [3:0] dbg_or;

  // Phase register: IDLE until the first sync, then free-running A1..X3.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= IDLE;
    end else begin
      phase <= phase_nxt;
    end
  end

  // Next phase: sync always realigns to A1; IDLE holds; X3 wraps to A1.
  always_comb begin
    phase_nxt = phase;
    if (sync) begin
      phase_nxt = A1;
    end else begin
      unique case (phase)
        IDLE:    phase_nxt = IDLE;
        A1:      phase_nxt = A2;
        A2:      phase_nxt = A3;
        A3:      phase_nxt = M1;
        M1:      phase_nxt = M2;
        M2:      phase_nxt = X1;
        X1:      phase_nxt = X2;
        X2:      phase_nxt = X3;
        X3:      phase_nxt = A1;
        default: phase_nxt = IDLE;
      endcase
    end
  end

  // SRC and I/O latches. The chip/reg latch and an I/O write share the X2
  // edge, so an I/O in the same cycle as an SRC sees the previous address.
  always_ff @(posedge clock) begin
    if (reset) begin
      chip_sel    <= '0;
      reg_sel     <= '0;
      char_sel    <= '0;
      opa         <= '0;
      io_cycle    <= 1'b0;
      src_pending <= 1'b0;
    end else begin
      src_pending <= (phase == X2) && cm_ram;
      if ((phase == X2) && cm_ram) begin
        chip_sel <= data_in[3:2];
        reg_sel  <= data_in[1:0];
      end
      if ((phase == X3) && src_pending) begin
        char_sel <= data_in;
      end
      if (phase_nxt == A1) begin
        io_cycle <= 1'b0;
      end else if ((phase == M2) && cm_ram) begin
        io_cycle <= 1'b1;
        opa      <= data_in;
      end
    end
  end

  assign io_x2 = (phase == X2) && io_cycle;

  for (genvar k = 0; k < NUM_CHIPS; k++) begin : g_chip
    ram4002_chip #(
      .CHIP_ID   (k),
      .NUM_REGS  (NUM_REGS),
      .NUM_CHARS (NUM_CHARS),
      .NUM_STATUS(NUM_STATUS)
    ) u_chip (
      .clock   (clock),
      .reset   (reset),
      .io_x2   (io_x2),
      .chip_sel(chip_sel),
      .reg_sel (reg_sel),
      .char_sel(char_sel),
      .opa     (opa),
      .data_in (data_in),
      .dbg_chip(dbg_chip),
      .dbg_addr(dbg_addr),
      .rd_en   (chip_rd_en[k]),
      .rd_data (chip_rd_data[k]),
      .port_out(port_out[4*k+:4]),
      .dbg_data(chip_dbg[k])
    );
  end

  // Merge chip outputs; at most one chip is ever selected, and unselected
  // chips drive zero, so a plain OR is the bus. Reset releases the bus at once.
  always_comb begin
    rd_any = 1'b0;
    rd_or  = '0;
    dbg_or = '0;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      rd_any = rd_any | chip_rd_en[k];
      rd_or  = rd_or | chip_rd_data[k];
      dbg_or = dbg_or | chip_dbg[k];
    end
    data_oe  = rd_any && !reset;
    data_out = data_oe ? rd_or : 4'h0;
    dbg_data = dbg_or;
  end

endmodule
